// File: rtl/descrypt_result_rx_pkg.sv
// Shared nibble-field positions and record-width helper for the result receiver.
package descrypt_result_rx_pkg;

  localparam int unsigned NIB_W              = 4;
  localparam int unsigned NIB_START_BIT      = 0;
  localparam int unsigned FLG_RSVD_BIT       = 3;
  localparam int unsigned FLG_KEY_VALID_BIT  = 2;
  localparam int unsigned FLG_EQUAL_BIT      = 1;
  localparam int unsigned FLG_BATCH_CMPL_BIT = 0;

  // Record layout, MSB first: batch, pkt, key_valid, equal, batch_complete, instance, addr
  function automatic int unsigned rx_rec_w(input int unsigned nb_msb,
                                           input int unsigned np_msb,
                                           input int unsigned addr_msb);
    return nb_msb + np_msb + 2 + 3 + 4 + addr_msb + 1;
  endfunction

endpackage

// File: rtl/descrypt_result_fifo.sv
// Small synchronous record FIFO (register-file storage) with a free-entry count.
module descrypt_result_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ok_c,
  input  logic             i_rd_en,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [$clog2(DEPTH):0] o_free_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd_ok;

  // A pop in the same cycle frees the slot the push needs, so full+pop still accepts.
  assign w_rd_ok    = i_rd_en && (r_count != '0);
  assign o_wr_ok_c  = i_wr_en && ((r_count != CW'(DEPTH)) || w_rd_ok);
  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_free_cnt = CW'(DEPTH) - r_count;

  // Storage array, no reset (maps to distributed RAM).
  always_ff @(posedge clk) begin
    if (o_wr_ok_c) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_wr_ok_c) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(o_wr_ok_c) - CW'(w_rd_ok);
    end
  end

endmodule

// File: rtl/descrypt_result_rx.sv
// Deserialises the comparator nibble stream into result records and queues them.
module descrypt_result_rx
  import descrypt_result_rx_pkg::*;
#(
  parameter int unsigned NUM_BATCHES_MSB = 0,
  parameter int unsigned NUM_PKTS_MSB    = 1,
  parameter int unsigned RAM_ADDR_MSB    = 11,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       CMP_CLK,
  input  logic                       RESET_N,
  input  logic [3:0]                 din,
  output logic                       dout_ready,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [NUM_BATCHES_MSB:0]   rec_batch,
  output logic [NUM_PKTS_MSB:0]      rec_pkt,
  output logic                       rec_key_valid,
  output logic                       rec_equal,
  output logic                       rec_batch_complete,
  output logic [3:0]                 rec_instance,
  output logic [RAM_ADDR_MSB:0]      rec_addr,
  output logic                       rx_error
);

  localparam int unsigned REC_W     = rx_rec_w(NUM_BATCHES_MSB, NUM_PKTS_MSB, RAM_ADDR_MSB);
  localparam int unsigned ADDR_W    = RAM_ADDR_MSB + 1;
  localparam int unsigned BP_W      = NUM_BATCHES_MSB + NUM_PKTS_MSB + 2;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned A2_HI_SH  = RAM_ADDR_MSB - 7;
  localparam int unsigned OFS_INST  = ADDR_W;
  localparam int unsigned OFS_BC    = ADDR_W + 4;
  localparam int unsigned OFS_EQ    = ADDR_W + 5;
  localparam int unsigned OFS_KV    = ADDR_W + 6;
  localparam int unsigned OFS_PKT   = ADDR_W + 7;
  localparam int unsigned OFS_BATCH = OFS_PKT + NUM_PKTS_MSB + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLAGS = 3'd1;
  localparam logic [2:0] S_INST  = 3'd2;
  localparam logic [2:0] S_A0    = 3'd3;
  localparam logic [2:0] S_A1    = 3'd4;
  localparam logic [2:0] S_A2    = 3'd5;
  localparam logic [2:0] S_TERM  = 3'd6;

  logic [2:0]      r_state;
  logic            r_resync;
  logic [BP_W-1:0] r_bp;
  logic            r_kv;
  logic            r_eq;
  logic            r_bc;
  logic [3:0]      r_inst;
  logic [7:0]      r_addr_lo;
  logic            r_err;
  logic            r_dout_ready;

  logic [2:0]      w_state_nxt;
  logic            w_push;
  logic            w_err_set;
  logic            w_start;
  logic [REC_W-1:0] w_rec;
  logic            w_wr_ok;
  logic            w_pop;
  logic [REC_W-1:0] w_head;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_free_nxt;
  logic            w_busy_nxt;
  logic            w_a2_hi_err;

  assign w_start     = !r_resync && din[NIB_START_BIT];
  assign w_a2_hi_err = (din >> A2_HI_SH) != '0;

  // Next-state, push request, protocol-error detection and record assembly.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    w_rec       = '0;
    case (r_state)
      S_IDLE: begin
        if (din != '0 && !r_resync) begin
          if (w_start) w_state_nxt = S_FLAGS;
          else         w_err_set   = 1'b1;
        end
      end
      S_FLAGS: begin
        if (din[FLG_RSVD_BIT] || din[2:0] == 3'd0) w_err_set = 1'b1;
        if (din[FLG_EQUAL_BIT]) begin
          w_state_nxt = S_INST;
        end else begin
          w_push      = 1'b1;
          w_rec       = {r_bp, din[FLG_KEY_VALID_BIT], din[FLG_EQUAL_BIT],
                         din[FLG_BATCH_CMPL_BIT], 4'd0, ADDR_W'(0)};
          w_state_nxt = S_TERM;
        end
      end
      S_INST:  w_state_nxt = S_A0;
      S_A0:    w_state_nxt = S_A1;
      S_A1:    w_state_nxt = S_A2;
      S_A2: begin
        if (w_a2_hi_err) w_err_set = 1'b1;
        w_push      = 1'b1;
        w_rec       = {r_bp, r_kv, r_eq, r_bc, r_inst, din[RAM_ADDR_MSB-8:0], r_addr_lo};
        w_state_nxt = S_TERM;
      end
      S_TERM: begin
        if (din != '0) w_err_set = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, resync tracking and sticky error.
  always_ff @(posedge CMP_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_resync <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && din == '0) r_resync <= 1'b0;
      r_err <= r_err | w_err_set | (w_push && !w_wr_ok);
    end
  end

  // Field capture registers for the record under assembly.
  always_ff @(posedge CMP_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bp      <= '0;
      r_kv      <= 1'b0;
      r_eq      <= 1'b0;
      r_bc      <= 1'b0;
      r_inst    <= '0;
      r_addr_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) r_bp <= din[NIB_W-1:1];
        S_FLAGS: begin
          r_kv <= din[FLG_KEY_VALID_BIT];
          r_eq <= din[FLG_EQUAL_BIT];
          r_bc <= din[FLG_BATCH_CMPL_BIT];
        end
        S_INST:  r_inst         <= din;
        S_A0:    r_addr_lo[3:0] <= din;
        S_A1:    r_addr_lo[7:4] <= din;
        default: ;
      endcase
    end
  end

  // Keep one spare slot beyond an in-flight transfer for the core's registered ready copy.
  assign w_free_nxt = w_free + CW'(w_pop) - CW'(w_wr_ok);
  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // Flow-control output, updated with the FIFO count and FSM state.
  always_ff @(posedge CMP_CLK or negedge RESET_N) begin
    if (!RESET_N) r_dout_ready <= 1'b0;
    else          r_dout_ready <= (w_free_nxt >= (CW'(2) + CW'(w_busy_nxt)));
  end

  assign w_pop = rec_valid && rec_ready;

  descrypt_result_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CMP_CLK),
    .rst_n      (RESET_N),
    .i_wr_en    (w_push),
    .i_wr_data  (w_rec),
    .o_wr_ok_c  (w_wr_ok),
    .i_rd_en    (rec_ready),
    .o_rd_valid (rec_valid),
    .o_rd_data  (w_head),
    .o_free_cnt (w_free)
  );

  assign dout_ready         = r_dout_ready;
  assign rx_error           = r_err;
  assign rec_batch          = w_head[OFS_BATCH +: NUM_BATCHES_MSB+1];
  assign rec_pkt            = w_head[OFS_PKT +: NUM_PKTS_MSB+1];
  assign rec_key_valid      = w_head[OFS_KV];
  assign rec_equal          = w_head[OFS_EQ];
  assign rec_batch_complete = w_head[OFS_BC];
  assign rec_instance       = w_head[OFS_INST +: 4];
  assign rec_addr           = w_head[ADDR_W-1:0];

endmodule

// File: tb/tb_descrypt_result_rx.sv
// Directed bench for descrypt_result_rx with hand-computed expected records.
module tb_descrypt_result_rx;

  logic        CMP_CLK;
  logic        RESET_N;
  logic [3:0]  din;
  logic        dout_ready;
  logic        rec_valid;
  logic        rec_ready;
  logic [0:0]  rec_batch;
  logic [1:0]  rec_pkt;
  logic        rec_key_valid;
  logic        rec_equal;
  logic        rec_batch_complete;
  logic [3:0]  rec_instance;
  logic [11:0] rec_addr;
  logic        rx_error;

  int n_vec = 0;
  int n_err = 0;

  descrypt_result_rx #(
    .NUM_BATCHES_MSB (0),
    .NUM_PKTS_MSB    (1),
    .RAM_ADDR_MSB    (11),
    .FIFO_DEPTH      (4)
  ) dut (
    .CMP_CLK            (CMP_CLK),
    .RESET_N            (RESET_N),
    .din                (din),
    .dout_ready         (dout_ready),
    .rec_valid          (rec_valid),
    .rec_ready          (rec_ready),
    .rec_batch          (rec_batch),
    .rec_pkt            (rec_pkt),
    .rec_key_valid      (rec_key_valid),
    .rec_equal          (rec_equal),
    .rec_batch_complete (rec_batch_complete),
    .rec_instance       (rec_instance),
    .rec_addr           (rec_addr),
    .rx_error           (rx_error)
  );

  initial CMP_CLK = 1'b0;
  always #5 CMP_CLK = ~CMP_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] b, input logic [31:0] p,
                         input logic [31:0] kv, input logic [31:0] eq, input logic [31:0] bc,
                         input logic [31:0] inst, input logic [31:0] addr);
    chk({tag, ".valid"}, 32'(rec_valid), 32'd1);
    chk({tag, ".batch"}, 32'(rec_batch), b);
    chk({tag, ".pkt"},   32'(rec_pkt), p);
    chk({tag, ".kv"},    32'(rec_key_valid), kv);
    chk({tag, ".eq"},    32'(rec_equal), eq);
    chk({tag, ".bc"},    32'(rec_batch_complete), bc);
    chk({tag, ".inst"},  32'(rec_instance), inst);
    chk({tag, ".addr"},  32'(rec_addr), addr);
  endtask

  // Present one nibble and let the DUT sample it; return 1 ns after the edge.
  task automatic nib(input logic [3:0] v);
    din = v;
    @(posedge CMP_CLK);
    #1;
  endtask

  task automatic pop();
    rec_ready = 1'b1;
    @(posedge CMP_CLK);
    #1;
    rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    @(posedge CMP_CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N   = 1'b0;
    din       = 4'h0;
    rec_ready = 1'b0;
    #12;
    // Reset values
    chk("rst.dout_ready", 32'(dout_ready), 32'd0);
    chk("rst.rec_valid",  32'(rec_valid), 32'd0);
    chk("rst.rx_error",   32'(rx_error), 32'd0);
    chk("rst.rec_pkt",    32'(rec_pkt), 32'd0);
    chk("rst.rec_addr",   32'(rec_addr), 32'd0);
    @(posedge CMP_CLK);
    #1;
    RESET_N = 1'b1;
    chk("rel.dout_ready_pre", 32'(dout_ready), 32'd0);

    // Batch complete only: 0,B,1,0
    nib(4'h0);
    chk("rel.dout_ready_post", 32'(dout_ready), 32'd1);
    nib(4'hB);
    chk("bc.valid_early", 32'(rec_valid), 32'd0);
    nib(4'h1);
    chk_rec("bc", 1, 1, 0, 0, 1, 0, 32'h000);
    nib(4'h0);
    chk("bc.err", 32'(rx_error), 32'd0);
    pop();
    chk("bc.empty", 32'(rec_valid), 32'd0);

    // Match: 5,6,3,A,5,2,0
    nib(4'h5); nib(4'h6); nib(4'h3); nib(4'hA); nib(4'h5);
    chk("m.valid_early", 32'(rec_valid), 32'd0);
    nib(4'h2);
    chk_rec("m", 0, 2, 1, 1, 0, 3, 32'h25A);
    nib(4'h0);
    pop();

    // Match plus batch complete, instance 15, addr FFF
    nib(4'h3); nib(4'h7); nib(4'hF); nib(4'hF); nib(4'hF); nib(4'hF);
    chk_rec("mbc", 0, 1, 1, 1, 1, 15, 32'hFFF);
    nib(4'h0);
    chk("mbc.err", 32'(rx_error), 32'd0);
    pop();

    // Backpressure with rec_ready held low
    nib(4'h1); nib(4'h1); nib(4'h0);
    nib(4'h3); nib(4'h1);
    chk("bp.ready_fall", 32'(dout_ready), 32'd0);
    nib(4'h0);
    chk("bp.ready_idle2", 32'(dout_ready), 32'd1);
    nib(4'h5); nib(4'h1); nib(4'h0);
    chk("bp.err3", 32'(rx_error), 32'd0);
    nib(4'h7); nib(4'h1); nib(4'h0);
    chk("bp.err4", 32'(rx_error), 32'd0);
    chk("bp.ready_full", 32'(dout_ready), 32'd0);
    nib(4'h9); nib(4'h1);
    chk("bp.err5", 32'(rx_error), 32'd1);
    nib(4'h0);
    for (int i = 0; i < 4; i++) begin
      chk_rec($sformatf("bp.drain%0d", i), 0, 32'(i), 0, 0, 1, 0, 0);
      pop();
    end
    chk("bp.empty", 32'(rec_valid), 32'd0);
    chk("bp.ready_back", 32'(dout_ready), 32'd1);

    // Protocol error: 0x2 in IDLE
    do_reset();
    nib(4'h0);
    chk("pe.err_clr", 32'(rx_error), 32'd0);
    nib(4'h2);
    chk("pe.idle_err", 32'(rx_error), 32'd1);
    chk("pe.no_rec", 32'(rec_valid), 32'd0);
    nib(4'h0);

    // Protocol error: reserved flag bit
    do_reset();
    nib(4'h0); nib(4'h1);
    chk("pe.pre_flag", 32'(rx_error), 32'd0);
    nib(4'h8);
    chk("pe.flag_err", 32'(rx_error), 32'd1);
    nib(4'h0);

    // Reset mid-transfer after INST nibble, then trailing nibbles
    do_reset();
    nib(4'h0); nib(4'h5); nib(4'h6); nib(4'h3);
    do_reset();
    nib(4'hA); nib(4'h5); nib(4'h2); nib(4'h0);
    chk("rmt.no_rec", 32'(rec_valid), 32'd0);
    chk("rmt.err", 32'(rx_error), 32'd0);
    nib(4'h5); nib(4'h6); nib(4'h3); nib(4'hA); nib(4'h5); nib(4'h2);
    chk_rec("rmt.clean", 0, 2, 1, 1, 0, 3, 32'h25A);
    nib(4'h0);
    chk("rmt.err_end", 32'(rx_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
